// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, sequencer state encoding and control-word bit indices for the SAP-1 controller.
package sap_pkg;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // T1..T6 live in the ring counter; the FSM only tracks which mode owns it.
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

    localparam int CW_CP = 0;
    localparam int CW_EP = 1;
    localparam int CW_EA = 2;
    localparam int CW_SU = 3;
    localparam int CW_EU = 4;
    localparam int CW_LM = 5;
    localparam int CW_CE = 6;
    localparam int CW_LI = 7;
    localparam int CW_EI = 8;
    localparam int CW_LA = 9;
    localparam int CW_LB = 10;
    localparam int CW_LO = 11;
    localparam int CW_W  = 12;
endpackage

// File: rtl/sap_controller_ring_counter.sv
// ring_counter: 6-bit one-hot T-state ring with synchronous clear to T1 and rotate enable.
module ring_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [5:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 6'b000001;
        else if (clr) q <= 6'b000001;
        else if (en) q <= {q[4:0], q[5]};
    end
endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP-1 T-state sequencer with run/single-step control and control-word decode.
module sap_controller
    import sap_pkg::*;
#(
    parameter logic [3:0] HLT_OP = OP_HLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       run,
    input  logic       step,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       n_lm,
    output logic       n_ce,
    output logic       n_li,
    output logic       n_ei,
    output logic       n_la,
    output logic       n_lb,
    output logic       n_lo,
    output logic       halted
);
    state_t            state, state_nx;
    logic [3:0]        op_q;
    logic              step_q, adv, rc_en, rc_clr;
    logic [5:0]        ring, t;
    logic [CW_W-1:0]   cw;
    logic              live, is_lda, is_add, is_sub, is_alu, is_mem, is_out;

    // run dominates; a step edge coinciding with run is absorbed by the same advance
    assign adv = run | (step & ~step_q);

    ring_counter u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rc_en),
        .clr   (rc_clr),
        .q     (ring)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= 4'h0;
            step_q <= 1'b0;
        end else begin
            state  <= state_nx;
            step_q <= step;
            if (rc_en && ring[2]) op_q <= opcode;
        end
    end

    always_comb begin
        rc_en    = (state == ST_RUN) && adv;
        rc_clr   = state != ST_RUN;
        state_nx = state;
        if (state == ST_IDLE && adv) state_nx = ST_RUN;
        else if (rc_en && ring[3] && op_q == HLT_OP) state_nx = ST_HALT;
    end

    assign t      = (state == ST_RUN) ? ring : 6'b0;
    assign live   = op_q != HLT_OP;
    assign is_lda = live && op_q == OP_LDA;
    assign is_add = live && op_q == OP_ADD;
    assign is_sub = live && op_q == OP_SUB;
    assign is_alu = is_add | is_sub;
    assign is_mem = is_lda | is_alu;
    assign is_out = live && op_q == OP_OUT;

    always_comb begin
        cw        = '0;
        cw[CW_EP] = t[0];
        cw[CW_CP] = t[1];
        cw[CW_LM] = t[0] | (t[3] & is_mem);
        cw[CW_CE] = t[2] | (t[4] & is_mem);
        cw[CW_LI] = t[2];
        cw[CW_EI] = t[3] & is_mem;
        cw[CW_EA] = t[3] & is_out;
        cw[CW_LO] = t[3] & is_out;
        cw[CW_LA] = (t[4] & is_lda) | (t[5] & is_alu);
        cw[CW_LB] = t[4] & is_alu;
        cw[CW_EU] = t[5] & is_alu;
        cw[CW_SU] = t[5] & is_sub;
    end

    assign t_state = t;
    assign halted  = state == ST_HALT;
    assign cp      = cw[CW_CP];
    assign ep      = cw[CW_EP];
    assign ea      = cw[CW_EA];
    assign su      = cw[CW_SU];
    assign eu      = cw[CW_EU];
    assign n_lm    = ~cw[CW_LM];
    assign n_ce    = ~cw[CW_CE];
    assign n_li    = ~cw[CW_LI];
    assign n_ei    = ~cw[CW_EI];
    assign n_la    = ~cw[CW_LA];
    assign n_lb    = ~cw[CW_LB];
    assign n_lo    = ~cw[CW_LO];
endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: directed vectors into a scoreboard queue, checked by a separate monitor.
module tb_sap_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, run = 1'b0, step = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [5:0] t_state;
    logic       cp, ep, ea, su, eu, n_lm, n_ce, n_li, n_ei, n_la, n_lb, n_lo, halted;
    logic [11:0] ctrl;

    // control word order: {cp,ep,ea,su,eu, n_lm,n_ce,n_li,n_ei,n_la,n_lb,n_lo}
    localparam logic [11:0] W_IDL = 12'b00000_1111111;
    localparam logic [11:0] W_T1  = 12'b01000_0111111;
    localparam logic [11:0] W_T2  = 12'b10000_1111111;
    localparam logic [11:0] W_T3  = 12'b00000_1001111;
    localparam logic [11:0] W_T4M = 12'b00000_0110111;
    localparam logic [11:0] W_T4O = 12'b00100_1111110;
    localparam logic [11:0] W_T5L = 12'b00000_1011011;
    localparam logic [11:0] W_T5A = 12'b00000_1011101;
    localparam logic [11:0] W_T6A = 12'b00001_1111011;
    localparam logic [11:0] W_T6S = 12'b00011_1111011;

    typedef struct {
        int         id;
        logic [5:0] t;
        logic [11:0] c;
        logic       h;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, n_id = 0;
    event sample;

    always #5 clk = ~clk;

    sap_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .run     (run),
        .step    (step),
        .t_state (t_state),
        .cp      (cp),
        .ep      (ep),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .n_lm    (n_lm),
        .n_ce    (n_ce),
        .n_li    (n_li),
        .n_ei    (n_ei),
        .n_la    (n_la),
        .n_lb    (n_lb),
        .n_lo    (n_lo),
        .halted  (halted)
    );

    assign ctrl = {cp, ep, ea, su, eu, n_lm, n_ce, n_li, n_ei, n_la, n_lb, n_lo};

    task automatic push(input logic [5:0] t, input logic [11:0] c, input logic h);
        exp_t e;
        e.id = n_id; e.t = t; e.c = c; e.h = h;
        sb.push_back(e);
        n_id++;
    endtask

    task automatic tick(input logic r, input logic s, input logic [3:0] op,
                        input logic [5:0] t, input logic [11:0] c, input logic h);
        @(negedge clk);
        run = r; step = s; opcode = op;
        @(posedge clk);
        push(t, c, h);
    endtask

    // reset pulse entirely between clock edges, checked before the next rising edge
    task automatic async_reset();
        @(negedge clk);
        #1 rst_n = 1'b0; run = 1'b0; step = 1'b0;
        push(6'h00, W_IDL, 1'b0);
        #1 -> sample;
        #1 rst_n = 1'b1;
    endtask

    initial forever begin
        @(negedge clk or sample);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            if ({t_state, ctrl, halted} !== {e.t, e.c, e.h}) begin
                n_fail++;
                $display("FAIL vec %0d: got t_state=%h ctrl=%b halted=%b, expected t_state=%h ctrl=%b halted=%b",
                         e.id, t_state, ctrl, halted, e.t, e.c, e.h);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick(0, 0, 4'h0, 6'h00, W_IDL, 0);
        #1 rst_n = 1'b1;
        tick(0, 0, 4'h0, 6'h00, W_IDL, 0);
        // LDA free-running
        tick(1, 0, 4'h0, 6'h01, W_T1,  0);
        tick(1, 0, 4'h0, 6'h02, W_T2,  0);
        tick(1, 0, 4'h0, 6'h04, W_T3,  0);
        tick(1, 0, 4'h0, 6'h08, W_T4M, 0);
        tick(1, 0, 4'h0, 6'h10, W_T5L, 0);
        tick(1, 0, 4'h0, 6'h20, W_IDL, 0);
        tick(1, 0, 4'h0, 6'h01, W_T1,  0);
        // SUB
        tick(1, 0, 4'h2, 6'h02, W_T2,  0);
        tick(1, 0, 4'h2, 6'h04, W_T3,  0);
        tick(1, 0, 4'h2, 6'h08, W_T4M, 0);
        tick(1, 0, 4'h2, 6'h10, W_T5A, 0);
        tick(1, 0, 4'h2, 6'h20, W_T6S, 0);
        tick(1, 0, 4'h2, 6'h01, W_T1,  0);
        // single step: 3-cycle pulse advances once, run+edge advances once
        tick(0, 1, 4'h0, 6'h02, W_T2,  0);
        tick(0, 1, 4'h0, 6'h02, W_T2,  0);
        tick(0, 1, 4'h0, 6'h02, W_T2,  0);
        tick(0, 0, 4'h0, 6'h02, W_T2,  0);
        tick(0, 1, 4'h0, 6'h04, W_T3,  0);
        tick(0, 0, 4'h0, 6'h04, W_T3,  0);
        tick(1, 1, 4'h0, 6'h08, W_T4M, 0);
        tick(0, 1, 4'h0, 6'h08, W_T4M, 0);
        tick(0, 0, 4'h0, 6'h08, W_T4M, 0);
        tick(0, 1, 4'h0, 6'h10, W_T5L, 0);
        tick(1, 0, 4'h0, 6'h20, W_IDL, 0);
        tick(1, 0, 4'h0, 6'h01, W_T1,  0);
        // ADD latched, opcode switched to OUT during T5
        tick(1, 0, 4'h1, 6'h02, W_T2,  0);
        tick(1, 0, 4'h1, 6'h04, W_T3,  0);
        tick(1, 0, 4'h1, 6'h08, W_T4M, 0);
        tick(1, 0, 4'hE, 6'h10, W_T5A, 0);
        tick(1, 0, 4'hE, 6'h20, W_T6A, 0);
        tick(1, 0, 4'hE, 6'h01, W_T1,  0);
        // OUT
        tick(1, 0, 4'hE, 6'h02, W_T2,  0);
        tick(1, 0, 4'hE, 6'h04, W_T3,  0);
        tick(1, 0, 4'hE, 6'h08, W_T4O, 0);
        tick(1, 0, 4'hE, 6'h10, W_IDL, 0);
        tick(1, 0, 4'hE, 6'h20, W_IDL, 0);
        tick(1, 0, 4'hE, 6'h01, W_T1,  0);
        // reset in the middle of T5
        tick(1, 0, 4'h0, 6'h02, W_T2,  0);
        tick(1, 0, 4'h0, 6'h04, W_T3,  0);
        tick(1, 0, 4'h0, 6'h08, W_T4M, 0);
        tick(1, 0, 4'h0, 6'h10, W_T5L, 0);
        async_reset();
        tick(0, 0, 4'h0, 6'h00, W_IDL, 0);
        tick(1, 0, 4'h0, 6'h01, W_T1,  0);
        // HLT
        tick(1, 0, 4'hF, 6'h02, W_T2,  0);
        tick(1, 0, 4'hF, 6'h04, W_T3,  0);
        tick(1, 0, 4'hF, 6'h08, W_IDL, 0);
        tick(1, 0, 4'hF, 6'h00, W_IDL, 1);
        tick(1, 1, 4'hF, 6'h00, W_IDL, 1);
        tick(0, 0, 4'hF, 6'h00, W_IDL, 1);
        tick(0, 1, 4'hF, 6'h00, W_IDL, 1);
        async_reset();
        tick(0, 0, 4'h0, 6'h00, W_IDL, 0);
        tick(0, 1, 4'h0, 6'h01, W_T1,  0);
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 Parameter HLT_OP, default 4'hF, is the opcode that halts the sequencer.
REQ-002 clk  input  1  single system clock; all state updates occur on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  4  instruction register opcode field.
REQ-005 run  input  1  level; 1 = free-running, one T-state per clock.
REQ-006 step  input  1  single-step request; each rising edge advances one T-state.
REQ-007 t_state  output  6  one-hot T1..T6 (bit0 = T1); all-zero when IDLE or HALT.
REQ-008 cp, ep, ea, su, eu  output  1 each  active-high: PC increment, PC enable, A enable, subtract, ALU enable.
REQ-009 n_lm, n_ce, n_li, n_ei, n_la, n_lb, n_lo  output  1 each  active-low: MAR load, RAM enable, IR load, IR enable, A load, B load, output-register load.
REQ-010 halted  output  1  high while in HALT.

Function
REQ-011 The block SHALL have the states IDLE, T1..T6 and HALT.
REQ-012 IDLE SHALL go to T1 on the clock edge where run=1 or a step edge is detected; otherwise it stays in IDLE.
REQ-013 In T1..T6, run=1 SHALL advance one state per clock: T1->T2->...->T6->T1, with T6 wrapping to T1.
REQ-014 In T1..T6 with run=0, the state SHALL advance only on the clock after a detected step edge and SHALL hold otherwise.
REQ-015 A step edge is defined as step=1 with the registered previous step=0; exactly one advance per edge, regardless of pulse length.
REQ-016 When run=1 and a step edge occur together, run SHALL dominate: one advance only, and the edge is consumed.
REQ-017 The opcode SHALL be latched into an internal op_q on the T3->T4 transition; T4..T6 decoding SHALL use only op_q.
REQ-018 In any state, control outputs not listed below SHALL be inactive (active-high = 0, active-low = 1).
REQ-019 T1: ep=1, n_lm=0.
REQ-020 T2: cp=1.
REQ-021 T3: n_ce=0, n_li=0.
REQ-022 T4 with op_q LDA(0)/ADD(1)/SUB(2): n_ei=0, n_lm=0. T4 with OUT(4'hE): ea=1, n_lo=0.
REQ-023 T5 with LDA: n_ce=0, n_la=0. T5 with ADD/SUB: n_ce=0, n_lb=0.
REQ-024 T6 with ADD: eu=1, n_la=0. T6 with SUB: su=1, eu=1, n_la=0.
REQ-025 Any other op_q SHALL be a NOP in T4..T6 (all outputs inactive), and the sequence SHALL continue.
REQ-026 T4 with op_q=HLT_OP SHALL assert no control outputs; the next transition SHALL be to HALT, not T5.
REQ-027 HALT SHALL be absorbing, left only by reset: t_state=0, halted=1, all controls inactive, run and step ignored.
REQ-028 Control outputs and t_state SHALL be a pure decode of the registered state and op_q; there is no combinational path from run or step to any output.
REQ-029 Latency: a run or step edge sampled at edge k SHALL make T1 outputs visible after edge k (IDLE exit).

Reset
REQ-030 rst_n=0 SHALL force state=IDLE, op_q=0, step history=0, t_state=0, halted=0 and all controls inactive, immediately and independently of clk.
REQ-031 Reset asserted mid-instruction SHALL abandon the instruction; no partial control word persists.
REQ-032 Release SHALL be synchronous-safe: the first transition occurs no earlier than the first rising edge after rst_n=1.

Structure
REQ-033 A shared package sap_pkg SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT), the state encoding, and a control-word bit index list.
REQ-034 A single sub-module, ring_counter (6-bit one-hot, enable, clear, async active-low reset), SHALL generate T1..T6; the FSM wraps it with IDLE/HALT and the decode.

Verification
REQ-035 Run with opcode=0 (LDA): sequence T1..T6 with one-hot t_state 01,02,04,08,10,20; n_lm=0 in T1 and T4; n_la=0 in T5.
REQ-036 Run with opcode=2 (SUB): in T6, su=1, eu=1, n_la=0; in T5, n_lb=0; T1 follows T6.
REQ-037 run=0 with a 3-cycle step pulse: exactly one advance; holding step high produces no further advance.
REQ-038 Opcode changed to 4'hE during T5: outputs still follow the op_q value latched at T3->T4.
REQ-039 opcode=4'hF: after T4 the next state is HALT, halted=1, t_state=0; run and step ignored until rst_n=0, which returns the block to IDLE.
REQ-040 rst_n pulsed low during T5 between clock edges: outputs go inactive at once and the block is in IDLE after release.
